rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 32-entry integer register file. It shares the register file's single write port between two producers: requester A (ALU/CSR path) and requester B (load unit). It drives the port through a registered output stage. It also tracks outstanding destination registers so issue logic can stall on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file's wen/waddr/wdata inputs.

---
 rtl/rf_wb_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter and scoreboard for the integer register file.
//   Two producers (A: ALU/CSR, B: load unit) share the single register
//   file write port through a registered output stage. Round-robin
//   arbitration is used under contention. A busy mask tracks reserved
//   destination registers so issue can stall on RAW/WAW hazards.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   claim_valid, claim_addr    destination reservation from issue
//   a_valid/a_addr/a_data      requester A write-back, a_ready = grant
//   b_valid/b_addr/b_data      requester B write-back, b_ready = grant
//   wen, waddr, wdata          registered register file write port
//   chk_addra, chk_addrb       source indices checked by issue
//   hazard_a, hazard_b         source not yet readable from the register file
//   busy                       registered scoreboard mask (bit 0 always 0)
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         claim_valid,
    input  logic [ADDR_WIDTH-1:0]        claim_addr,
    input  logic                         a_valid,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [DATA_WIDTH-1:0]        a_data,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_WIDTH-1:0]        b_data,
    output logic                         b_ready,
    output logic                         wen,
    output logic [ADDR_WIDTH-1:0]        waddr,
    output logic [DATA_WIDTH-1:0]        wdata,
    input  logic [ADDR_WIDTH-1:0]        chk_addra,
    input  logic [ADDR_WIDTH-1:0]        chk_addrb,
    output logic                         hazard_a,
    output logic                         hazard_b,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t                        last_q;
    last_t                        last_d;
    logic                         grant;
    logic [ADDR_WIDTH-1:0]        gnt_addr;
    logic [DATA_WIDTH-1:0]        gnt_data;
    logic [(1<<ADDR_WIDTH)-1:0]   busy_d;

    // Last-grant pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Next pointer: follows whoever was granted this cycle
    always_comb begin
        last_d = last_q;
        if (a_ready) begin
            last_d = LAST_A;
        end else if (b_ready) begin
            last_d = LAST_B;
        end
    end

    // Grant decode: depends only on valids, pointer and rst
    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        if (!rst) begin
            a_ready = a_valid && (!b_valid || (last_q == LAST_B));
            b_ready = b_valid && (!a_valid || (last_q == LAST_A));
        end
        grant    = a_ready || b_ready;
        gnt_addr = a_ready ? a_addr : b_addr;
        gnt_data = a_ready ? a_data : b_data;
    end

    // Registered write port; x0 writes are consumed with wen low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (grant) begin
            wen   <= (gnt_addr != '0);
            waddr <= gnt_addr;
            wdata <= gnt_data;
        end else begin
            wen   <= 1'b0;
        end
    end

    // Scoreboard update: clear on grant first, then a claim overrides it
    always_comb begin
        busy_d = busy;
        if (grant) begin
            busy_d[gnt_addr] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    // The output-register term covers the cycle between grant and the
    // register file actually capturing the data.
    assign hazard_a = (chk_addra != '0) &&
                      (busy[chk_addra] || (wen && (waddr == chk_addra)));
    assign hazard_b = (chk_addrb != '0) &&
                      (busy[chk_addrb] || (wen && (waddr == chk_addrb)));

endmodule
